// File: rtl/death_handler.sv
// Mario/goomba death sequencing: death animation, lives, goomba squash lifetime,
// score accumulation and game-over / new-game handling.
module death_handler #(
    parameter int SQUASH_FRAMES   = 30,
    parameter int DEATH_UP_FRAMES = 20,
    parameter int DEATH_FRAMES    = 90,
    parameter int START_LIVES     = 3,
    parameter int GOOMBA_POINTS   = 100
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               is_Mario_die,
    input  logic               is_goomba_die,
    input  logic               start_btn,
    output logic               level_restart,
    output logic               freeze,
    output logic               goomba_visible,
    output logic               goomba_squashed,
    output logic signed [12:0] Mario_Death_Y_Ofs,
    output logic [2:0]         lives,
    output logic [15:0]        score,
    output logic               game_over
);

    localparam int DW = $clog2(DEATH_FRAMES + 1);
    localparam int SW = $clog2(SQUASH_FRAMES + 1);

    typedef enum logic [1:0] {PLAY, DYING, RESTART, GAME_OVER} mario_state_t;
    typedef enum logic [1:0] {G_ACTIVE, G_SQUASH, G_GONE} goomba_state_t;

    mario_state_t  mstate;
    goomba_state_t gstate;

    logic          fs1, fs2, fs3;
    logic          mario_q, mario_q2, goomba_q, goomba_q2;
    logic          frame_tick, mario_ev, goomba_ev, goomba_kill;
    logic [DW-1:0] death_cnt;
    logic [SW-1:0] squash_cnt;
    logic [16:0]   score_sum;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fs1       <= 1'b0;
            fs2       <= 1'b0;
            fs3       <= 1'b0;
            mario_q   <= 1'b0;
            mario_q2  <= 1'b0;
            goomba_q  <= 1'b0;
            goomba_q2 <= 1'b0;
        end else begin
            fs1       <= frame_clk;
            fs2       <= fs1;
            fs3       <= fs2;
            mario_q   <= is_Mario_die;
            mario_q2  <= mario_q;
            goomba_q  <= is_goomba_die;
            goomba_q2 <= goomba_q;
        end
    end

    assign frame_tick  = fs2 & ~fs3;
    assign mario_ev    = mario_q & ~mario_q2;
    assign goomba_ev   = goomba_q & ~goomba_q2;
    // Goomba kills only count while Mario is alive and the goomba is still walking.
    assign goomba_kill = goomba_ev && (gstate == G_ACTIVE) && (mstate == PLAY);
    assign score_sum   = {1'b0, score} + 17'(GOOMBA_POINTS);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mstate            <= PLAY;
            death_cnt         <= '0;
            Mario_Death_Y_Ofs <= '0;
            lives             <= 3'(START_LIVES);
            level_restart     <= 1'b0;
            freeze            <= 1'b0;
            game_over         <= 1'b0;
        end else begin
            case (mstate)
                PLAY: begin
                    if (mario_ev) begin
                        mstate            <= DYING;
                        death_cnt         <= '0;
                        Mario_Death_Y_Ofs <= '0;
                        freeze            <= 1'b1;
                    end
                end
                DYING: begin
                    if (frame_tick) begin
                        if (death_cnt < DW'(DEATH_UP_FRAMES))
                            Mario_Death_Y_Ofs <= Mario_Death_Y_Ofs - 13'sd2;
                        else
                            Mario_Death_Y_Ofs <= Mario_Death_Y_Ofs + 13'sd3;
                        death_cnt <= death_cnt + 1'b1;
                        if (death_cnt == DW'(DEATH_FRAMES - 1)) begin
                            if (lives > 3'd1) begin
                                lives         <= lives - 3'd1;
                                mstate        <= RESTART;
                                level_restart <= 1'b1;
                                freeze        <= 1'b0;
                            end else begin
                                // Freeze stays asserted through game over.
                                lives     <= 3'd0;
                                mstate    <= GAME_OVER;
                                game_over <= 1'b1;
                            end
                        end
                    end
                end
                RESTART: begin
                    level_restart     <= 1'b0;
                    Mario_Death_Y_Ofs <= '0;
                    mstate            <= PLAY;
                end
                GAME_OVER: begin
                    if (start_btn) begin
                        lives         <= 3'(START_LIVES);
                        mstate        <= RESTART;
                        level_restart <= 1'b1;
                        freeze        <= 1'b0;
                        game_over     <= 1'b0;
                    end
                end
                default: mstate <= PLAY;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            gstate          <= G_ACTIVE;
            squash_cnt      <= '0;
            goomba_visible  <= 1'b1;
            goomba_squashed <= 1'b0;
        end else if (level_restart) begin
            gstate          <= G_ACTIVE;
            squash_cnt      <= '0;
            goomba_visible  <= 1'b1;
            goomba_squashed <= 1'b0;
        end else begin
            case (gstate)
                G_ACTIVE: begin
                    if (goomba_kill) begin
                        gstate          <= G_SQUASH;
                        squash_cnt      <= '0;
                        goomba_squashed <= 1'b1;
                    end
                end
                G_SQUASH: begin
                    if (frame_tick && !freeze) begin
                        squash_cnt <= squash_cnt + 1'b1;
                        if (squash_cnt == SW'(SQUASH_FRAMES - 1)) begin
                            gstate          <= G_GONE;
                            goomba_visible  <= 1'b0;
                            goomba_squashed <= 1'b0;
                        end
                    end
                end
                G_GONE: ;
                default: gstate <= G_ACTIVE;
            endcase
        end
    end

    // New game clears score; kills cannot coincide since they need Mario in PLAY.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            score <= '0;
        else if (mstate == GAME_OVER && start_btn)
            score <= '0;
        else if (goomba_kill)
            score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

endmodule

// File: tb/tb_death_handler.sv
// Directed bench for death_handler: expectations queued at stimulus time,
// popped and compared once the DUT has had time to respond.
module tb_death_handler;

    logic Clk = 1'b0, Reset = 1'b0, frame_clk = 1'b0, start_btn = 1'b0;
    logic m = 1'b0, g = 1'b0, m2 = 1'b0, g2 = 1'b0;

    logic               level_restart, freeze, goomba_visible, goomba_squashed, game_over;
    logic signed [12:0] ofs;
    logic [2:0]         lives;
    logic [15:0]        score;

    logic               level_restart2, freeze2, goomba_visible2, goomba_squashed2, game_over2;
    logic signed [12:0] ofs2;
    logic [2:0]         lives2;
    logic [15:0]        score2;

    death_handler dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .is_Mario_die(m), .is_goomba_die(g), .start_btn(start_btn),
        .level_restart(level_restart), .freeze(freeze),
        .goomba_visible(goomba_visible), .goomba_squashed(goomba_squashed),
        .Mario_Death_Y_Ofs(ofs), .lives(lives), .score(score), .game_over(game_over)
    );

    // Short animations and large points so saturation is reachable quickly.
    death_handler #(
        .SQUASH_FRAMES(2), .DEATH_UP_FRAMES(1), .DEATH_FRAMES(2),
        .START_LIVES(3), .GOOMBA_POINTS(32750)
    ) dut2 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .is_Mario_die(m2), .is_goomba_die(g2), .start_btn(start_btn),
        .level_restart(level_restart2), .freeze(freeze2),
        .goomba_visible(goomba_visible2), .goomba_squashed(goomba_squashed2),
        .Mario_Death_Y_Ofs(ofs2), .lives(lives2), .score(score2), .game_over(game_over2)
    );

    always #10 Clk = ~Clk;

    typedef struct {
        string              tag;
        logic signed [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0, miscompares = 0, rcnt = 0, r0 = 0;

    always @(posedge Clk) if (level_restart) rcnt++;

    task automatic push(input string tag, input logic signed [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic signed [31:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL sb_empty observed=%0d", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_clk = 1'b1;
            clks(3);
            frame_clk = 1'b0;
            clks(3);
        end
    endtask

    // Final death frame: raise frame_clk and stop inside the one-cycle RESTART.
    task automatic tick_to_restart(input string tag);
        bit seen = 1'b0;
        frame_clk = 1'b1;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge Clk);
            if (level_restart) seen = 1'b1;
        end
        push(tag, 1);
        pop_chk(32'(seen));
    endtask

    initial begin
        // Reset state
        clks(3);
        push("rst_lives", 3); push("rst_score", 0); push("rst_ofs", 0);
        push("rst_visible", 1); push("rst_squashed", 0); push("rst_freeze", 0);
        push("rst_game_over", 0); push("rst_restart", 0);
        pop_chk(lives); pop_chk(score); pop_chk($signed(ofs));
        pop_chk(goomba_visible); pop_chk(goomba_squashed); pop_chk(freeze);
        pop_chk(game_over); pop_chk(level_restart);
        Reset = 1'b1;
        clks(3);

        // Goomba stomp
        g = 1'b1;
        push("stomp_score", 100); push("stomp_squashed", 1);
        clks(3);
        pop_chk(score); pop_chk(goomba_squashed);
        ticks(29);
        push("squash_29_squashed", 1); push("squash_29_visible", 1);
        pop_chk(goomba_squashed); pop_chk(goomba_visible);
        ticks(1);
        push("squash_30_visible", 0); push("squash_30_squashed", 0);
        pop_chk(goomba_visible); pop_chk(goomba_squashed);
        g = 1'b0;
        clks(3);

        // First death, lives 3 -> 2
        r0 = rcnt;
        m = 1'b1;
        push("die1_freeze", 1); push("die1_ofs0", 0);
        clks(3);
        pop_chk(freeze); pop_chk($signed(ofs));
        ticks(20);
        push("die1_ofs20", -40);
        pop_chk($signed(ofs));
        ticks(69);
        push("die1_ofs89", 167); push("die1_lives89", 3);
        pop_chk($signed(ofs)); pop_chk(lives);
        tick_to_restart("die1_restart_seen");
        push("die1_ofs90", 170); push("die1_lives", 2);
        pop_chk($signed(ofs)); pop_chk(lives);
        frame_clk = 1'b0;
        clks(5);
        push("die1_pulses", 1); push("die1_freeze_after", 0);
        push("die1_ofs_after", 0); push("die1_goomba_back", 1);
        pop_chk(rcnt - r0); pop_chk(freeze); pop_chk($signed(ofs)); pop_chk(goomba_visible);
        // Flag still high after restart must not retrigger
        push("stale_flag_freeze", 0);
        pop_chk(freeze);
        m = 1'b0;
        clks(3);

        // Second death, goomba flag rises mid-animation
        m = 1'b1;
        clks(3);
        g = 1'b1;
        push("dying_goomba_score", 100); push("dying_goomba_squashed", 0);
        push("dying_goomba_visible", 1);
        clks(4);
        pop_chk(score); pop_chk(goomba_squashed); pop_chk(goomba_visible);
        ticks(89);
        tick_to_restart("die2_restart_seen");
        push("die2_lives", 1);
        pop_chk(lives);
        frame_clk = 1'b0;
        clks(3);
        m = 1'b0;
        g = 1'b0;
        clks(3);

        // Third death -> game over
        r0 = rcnt;
        m = 1'b1;
        clks(3);
        ticks(90);
        push("go_game_over", 1); push("go_lives", 0); push("go_freeze", 1);
        push("go_no_restart", 0);
        pop_chk(game_over); pop_chk(lives); pop_chk(freeze); pop_chk(rcnt - r0);
        m = 1'b0;
        clks(3);
        start_btn = 1'b1;
        clks(1);
        start_btn = 1'b0;
        clks(3);
        push("new_lives", 3); push("new_score", 0); push("new_pulses", 1);
        push("new_game_over", 0); push("new_freeze", 0);
        pop_chk(lives); pop_chk(score); pop_chk(rcnt - r0);
        pop_chk(game_over); pop_chk(freeze);

        // Score saturation and simultaneous events on the short-parameter instance
        g2 = 1'b1;
        push("sat_score1", 32750);
        clks(3);
        pop_chk(score2);
        m2 = 1'b1;
        clks(3);
        ticks(2);
        m2 = 1'b0;
        g2 = 1'b0;
        clks(3);
        g2 = 1'b1;
        push("sat_score2", 65500);
        clks(3);
        pop_chk(score2);
        m2 = 1'b1;
        clks(3);
        ticks(2);
        m2 = 1'b0;
        g2 = 1'b0;
        clks(3);
        m2 = 1'b1;
        g2 = 1'b1;
        push("sat_score3", 65535); push("simul_freeze", 1); push("simul_squashed", 1);
        clks(3);
        pop_chk(score2); pop_chk(freeze2); pop_chk(goomba_squashed2);

        // Reset in the middle of the death animation
        m = 1'b1;
        clks(3);
        ticks(45);
        push("mid_ofs45", 35);
        pop_chk($signed(ofs));
        Reset = 1'b0;
        push("arst_ofs", 0); push("arst_freeze", 0); push("arst_lives", 3);
        push("arst_score", 0); push("arst_visible", 1); push("arst_squashed", 0);
        push("arst_game_over", 0); push("arst_restart", 0); push("arst_score2", 0);
        #1;
        pop_chk($signed(ofs)); pop_chk(freeze); pop_chk(lives); pop_chk(score);
        pop_chk(goomba_visible); pop_chk(goomba_squashed); pop_chk(game_over);
        pop_chk(level_restart); pop_chk(score2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/death_handler.md
DEATH_HANDLER -- requirements
Module: death_handler

Interface
REQ-001 Parameter SQUASH_FRAMES, default 30, frames a squashed goomba stays visible before removal.
REQ-002 Parameter DEATH_UP_FRAMES, default 20, frames Mario rises during the death animation.
REQ-003 Parameter DEATH_FRAMES, default 90, total death-animation frames; SHALL exceed DEATH_UP_FRAMES.
REQ-004 Parameter START_LIVES, default 3, lives loaded at reset and new game; range 1..7.
REQ-005 Parameter GOOMBA_POINTS, default 100, score added per goomba kill.
REQ-006 Clk  in  1  50 MHz system clock; all state on rising edge.
REQ-007 Reset  in  1  asynchronous, active-low reset.
REQ-008 frame_clk  in  1  vertical-sync-rate clock; rising edge defines one frame tick.
REQ-009 is_Mario_die  in  1  latched Mario-death flag from the collision block.
REQ-010 is_goomba_die  in  1  latched goomba-death flag from the collision block.
REQ-011 start_btn  in  1  new-game request, level, sampled only in GAME_OVER.
REQ-012 level_restart  out  1  one-Clk pulse that clears the collision block and respawns positions.
REQ-013 freeze  out  1  high while motion blocks must hold position.
REQ-014 goomba_visible  out  1  goomba drawn.
REQ-015 goomba_squashed  out  1  draw the squashed goomba sprite.
REQ-016 Mario_Death_Y_Ofs  out  13  signed two's-complement vertical offset for the death animation.
REQ-017 lives  out  3  remaining lives.
REQ-018 score  out  16  unsigned score.
REQ-019 game_over  out  1  high in GAME_OVER.

Function
REQ-020 frame_clk SHALL be synchronised through two flops, then rising-edge detected; frame_tick is a one-Clk pulse.
REQ-021 is_Mario_die and is_goomba_die SHALL be registered once; a death event is the 0->1 edge of the registered value.
REQ-022 The Mario FSM SHALL have states PLAY, DYING, RESTART and GAME_OVER.
REQ-023 PLAY: a Mario death event moves the FSM to DYING; frame counter and Mario_Death_Y_Ofs are cleared to 0.
REQ-024 DYING, per frame_tick:
- frame count < DEATH_UP_FRAMES: offset -= 2.
- otherwise: offset += 3.
- counter increments.
REQ-025 DYING exit, on the frame_tick where counter == DEATH_FRAMES-1:
- lives > 1: lives -= 1, go to RESTART.
- lives == 1: lives = 0, go to GAME_OVER.
REQ-026 RESTART SHALL last exactly one Clk, assert level_restart, clear Mario_Death_Y_Ofs, then return to PLAY.
REQ-027 GAME_OVER: start_btn == 1 reloads lives = START_LIVES and score = 0, then enters RESTART.
REQ-028 freeze = 1 in DYING and GAME_OVER, else 0; game_over = 1 only in GAME_OVER.
REQ-029 The goomba FSM SHALL have states G_ACTIVE, G_SQUASH and G_GONE.
REQ-030 G_ACTIVE: a goomba death event while the Mario FSM is in PLAY:
- score += GOOMBA_POINTS, saturating at 16'hFFFF.
- go to G_SQUASH; squash counter cleared.
REQ-031 G_SQUASH: the counter increments per frame_tick; at SQUASH_FRAMES-1 go to G_GONE.
REQ-032 Goomba output decode:
- goomba_visible = 1 in G_ACTIVE and G_SQUASH.
- goomba_squashed = 1 only in G_SQUASH.
REQ-033 level_restart SHALL force the goomba FSM to G_ACTIVE in the same cycle, from any state.
REQ-034 Goomba death events outside PLAY SHALL be ignored (no score, no state change).
REQ-035 Simultaneous Mario and goomba events in PLAY: both take effect; score is added and Mario enters DYING.
REQ-036 Mario death events outside PLAY SHALL be ignored; a flag still high after RESTART produces no new event until it returns to 0.
REQ-037 The squash counter SHALL freeze while freeze = 1.

Reset
REQ-038 Reset low, at any time, SHALL asynchronously force these values:
- Mario FSM: PLAY; goomba FSM: G_ACTIVE.
- lives = START_LIVES, score = 0.
- all counters 0, Mario_Death_Y_Ofs = 0.
- level_restart = 0, freeze = 0, game_over = 0.
- goomba_visible = 1, goomba_squashed = 0.
- synchroniser and edge flops 0.
REQ-039 Reset asserted mid-DYING or mid-squash SHALL abandon the sequence without decrementing lives or adding score.

Verification
REQ-040 Goomba stomp: goomba flag 0->1 in PLAY -> score 100, goomba_squashed 1 for 30 frame ticks, then goomba_visible 0.
REQ-041 Mario death, lives 3 -> offset reaches -40 at frame 20 and +170 at frame 90; lives 2; one level_restart pulse; freeze low afterwards.
REQ-042 Three deaths from reset -> game_over 1, lives 0, no level_restart; start_btn -> lives 3, score 0, one level_restart pulse.
REQ-043 Goomba flag rises during DYING -> score unchanged, goomba stays G_ACTIVE.
REQ-044 Score preset near max: stomp at score 65500 -> score 65535.
REQ-045 Reset low at DYING frame 45 -> all outputs at reset values immediately; lives 3.
